// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the instruction memory, latches IR and
// computes the next PC (SEQ/BRANCH/JUMP/CALL/RET) with a return-address stack.
// Optional out-of-range fetch check is enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          RAS_DEPTH  = 4,
    parameter int          IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_update,
    input  logic [2:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] instruction,
    output logic [15:0] pc,
    output logic        enInst,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        ras_err,
    output logic        fetch_fault
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] SRC_SEQ    = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_CALL   = 3'd3;
    localparam logic [2:0] SRC_RET    = 3'd4;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 || IMEM_BYTES < 2) begin : g_param_err
        $error("fetch_stage: illegal RAS_DEPTH or IMEM_BYTES");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

    state_t        state, state_nxt;
    logic [15:0]   ras [RAS_DEPTH];
    logic [CW-1:0] cnt;
    logic          ld_ir, upd, fault_set;
    logic          push, pop, err_set;
    logic [15:0]   pc_seq, pc_jmp, pc_br, pc_nxt;
    logic [PW-1:0] top_idx, push_idx;
    logic          ras_full, ras_empty, oob;

    assign pc_seq    = pc + 16'd2;
    assign pc_jmp    = {pc[15:12], ir[11:0]};
    assign pc_br     = pc + {{11{ir[4]}}, ir[4:0]};
    assign ras_full  = (cnt == CW'(RAS_DEPTH));
    assign ras_empty = (cnt == '0);
    assign push_idx  = PW'(cnt);
    assign top_idx   = PW'(cnt - CW'(1));

`ifdef FETCH_BOUNDS_CHECK_EN
    // 17-bit compare so a PC near 16'hFFFF cannot wrap into range
    assign oob = ({1'b0, pc} + 17'd1) >= 17'(IMEM_BYTES);
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        enInst    = 1'b0;
        ld_ir     = 1'b0;
        upd       = 1'b0;
        fault_set = 1'b0;
        case (state)
            S_IDLE:  if (fetch_req) state_nxt = S_FETCH;
            S_FETCH: begin
                if (oob) begin
                    fault_set = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    enInst    = 1'b1;
                    ld_ir     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_update) begin
                    upd       = 1'b1;
                    state_nxt = fetch_req ? S_FETCH : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_nxt  = pc_seq;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (pc_src)
            SRC_BRANCH: pc_nxt = branch_taken ? pc_br : pc_seq;
            SRC_JUMP:   pc_nxt = pc_jmp;
            SRC_CALL: begin
                // a full stack drops the return address but the call still jumps
                pc_nxt  = pc_jmp;
                push    = !ras_full;
                err_set = ras_full;
            end
            SRC_RET: begin
                if (ras_empty) begin
                    err_set = 1'b1;
                end else begin
                    pc_nxt = ras[top_idx];
                    pop    = 1'b1;
                end
            end
            default: pc_nxt = pc_seq;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
            cnt      <= '0;
            ras_err  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else begin
            state    <= state_nxt;
            ir_valid <= ld_ir;
            if (ld_ir) ir <= instruction;
            if (upd) begin
                pc <= {pc_nxt[15:1], 1'b0};
                if (push) begin
                    ras[push_idx] <= pc_seq;
                    cnt           <= cnt + CW'(1);
                end
                if (pop) cnt <= cnt - CW'(1);
                if (err_set) ras_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         fetch_fault <= 1'b0;
        else if (fault_set) fetch_fault <= 1'b1;
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
